// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU and its one-bit slice.
//   alu_op_e    : operation encoding carried on op_i / into the slice.
//   ser_state_e : sequencer states of bit_serial_alu.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_ADD  = 2'b10,
        OP_ZERO = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_e;

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: purely combinational.
// Ports:
//   a, b    : operand bits
//   c_in    : carry-in (used only by OP_ADD)
//   op      : operation select
//   result  : result bit
//   c_out   : carry-out; 0 for every op except OP_ADD
module alu1
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    c_in,
    input  alu_op_e op,
    output logic    result,
    output logic    c_out
);

    always_comb begin
        result = 1'b0;
        c_out  = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = a ^ b ^ c_in;
                c_out  = (a & b) | (c_in & (a ^ b));
            end
            default: begin
                result = 1'b0;
                c_out  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial AND/OR/ADD unit. A WIDTH-bit request is evaluated LSB-first
// through a single alu1 slice over WIDTH cycles.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   start_valid_i / start_ready_o : request handshake (ready only in IDLE)
//   op_i, a_i, b_i                : operation and operands, sampled at accept
//   result_o, carry_o             : result word and ADD carry-out
//   done_valid_o / done_ready_i   : result handshake (valid only in DONE)
//   busy_o                        : high while an operation is in flight
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic             busy_o
);

    ser_state_e       state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic slice_result;
    logic slice_c_out;

    alu1 u_slice (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .c_in   (carry_q),
        .op     (op_q),
        .result (slice_result),
        .c_out  (slice_c_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= OP_AND;
            a_sh      <= '0;
            b_sh      <= '0;
            result_sh <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        a_sh    <= a_i;
                        b_sh    <= b_i;
                        op_q    <= alu_op_e'(op_i);
                        carry_q <= 1'b0;   // bit 0 adds with no carry-in
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    // Result bits enter at the MSB so that after WIDTH shifts
                    // bit 0 of the operands lands in bit 0 of the word.
                    result_sh <= {slice_result, result_sh[WIDTH-1:1]};
                    carry_q   <= (op_q == OP_ADD) ? slice_c_out : 1'b0;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    if (done_ready_i)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready_o = (state_q == IDLE);
    assign done_valid_o  = (state_q == DONE);
    assign busy_o        = (state_q == RUN) || (state_q == DONE);
    assign result_o      = result_sh;
    assign carry_o       = carry_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: a 32-bit instance for directed and
// random operations, and a 4-bit instance for an exhaustive sweep.
module tb_bit_serial_alu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        sv32, sr32, dv32, dr32, busy32, c32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, r32;

    // 4-bit instance
    logic        sv4, sr4, dv4, dr4, busy4, c4;
    logic [1:0]  op4;
    logic [3:0]  a4, b4, r4;

    bit_serial_alu #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .start_valid_i(sv32), .start_ready_o(sr32),
        .op_i(op32), .a_i(a32), .b_i(b32),
        .result_o(r32), .carry_o(c32),
        .done_valid_o(dv32), .done_ready_i(dr32), .busy_o(busy32)
    );

    bit_serial_alu #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .start_valid_i(sv4), .start_ready_o(sr4),
        .op_i(op4), .a_i(a4), .b_i(b4),
        .result_o(r4), .carry_o(c4),
        .done_valid_o(dv4), .done_ready_i(dr4), .busy_o(busy4)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on w-bit operands. Returns {carry, result}.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic [32:0] mask, sum, res;
        mask = (33'd1 << w) - 33'd1;
        sum  = ({1'b0, a} & mask) + ({1'b0, b} & mask);
        case (op)
            2'b00:   res = {1'b0, a & b} & mask;
            2'b01:   res = {1'b0, a | b} & mask;
            2'b10:   res = (sum & mask) | ({32'd0, sum[w]} << 32);
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 32-bit operation. Operands are scrambled while it runs; with bp set
    // the result is held under backpressure for 5 cycles with a stray request.
    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit bp);
        logic [32:0] exp;
        int lat;
        exp = model(op, a, b, 32);
        check({tag, ".ready"}, 64'(sr32), 64'd1);
        sv32 = 1'b1; op32 = op; a32 = a; b32 = b;
        tick();
        sv32 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (dv32) begin lat = n; break; end
            a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
            if (n == 5) check({tag, ".busy_run"}, 64'({busy32, sr32}), 64'b10);
        end
        check({tag, ".latency"}, 64'(lat), 64'd32);
        check({tag, ".result"}, 64'(r32), 64'(exp[31:0]));
        check({tag, ".carry"}, 64'(c32), 64'(exp[32]));
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                sv32 = (k == 2); op32 = 2'b01; a32 = $urandom; b32 = $urandom;
                tick();
                check({tag, ".bp_hold"}, {23'd0, dv32, busy32, sr32, c32, r32, 6'd0},
                      {23'd0, 1'b1, 1'b1, 1'b0, exp[32], exp[31:0], 6'd0});
            end
            sv32 = 1'b0;
        end
        dr32 = 1'b1;
        tick();
        dr32 = 1'b0;
        check({tag, ".after_hs"}, 64'({dv32, busy32, sr32}), 64'b001);
    endtask

    initial begin
        logic [32:0] exp;
        int lat, seen;
        rst_n = 1'b0;
        sv32 = 0; dr32 = 0; op32 = 0; a32 = 0; b32 = 0;
        sv4 = 0;  dr4 = 0;  op4 = 0;  a4 = 0;  b4 = 0;
        #3;
        check("reset32", {27'd0, sr32, dv32, busy32, c32, r32}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        check("reset4",  64'({sr4, dv4, busy4, c4, r4}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        run32("add_ovf", 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run32("and",     2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        run32("or",      2'b01, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        run32("zero",    2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run32("bp",      2'b10, 32'h8000_0001, 32'h8000_0003, 1'b1);
        // Issued the cycle after the handshake: the latency check proves accept.
        run32("post_bp", 2'b01, 32'h1234_5678, 32'h0F0F_0000, 1'b0);

        // Reset in the middle of an ADD.
        sv32 = 1'b1; op32 = 2'b10; a32 = 32'hFFFF_0000; b32 = 32'h0001_FFFF;
        tick();
        sv32 = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst", {27'd0, sr32, dv32, busy32, c32, r32}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (dv32 || busy32) seen++;
        end
        check("no_done_after_rst", 64'(seen), 64'd0);
        run32("rst_recover", 2'b10, 32'd5, 32'd7, 1'b0);

        for (int i = 0; i < 12; i++)
            run32("rand32", 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);

        // Exhaustive 4-bit sweep at maximum issue rate, consumer always ready.
        dr4 = 1'b1;
        for (int op = 0; op < 3; op++) begin
            for (int ab = 0; ab < 256; ab++) begin
                exp = model(2'(op), {28'd0, 4'(ab >> 4)}, {28'd0, 4'(ab)}, 4);
                check("w4.ready", 64'(sr4), 64'd1);
                sv4 = 1'b1; op4 = 2'(op); a4 = 4'(ab >> 4); b4 = 4'(ab);
                tick();
                sv4 = 1'b0;
                lat = 0;
                for (int n = 1; n <= 20; n++) begin
                    tick();
                    if (dv4) begin lat = n; break; end
                end
                check("w4.latency", 64'(lat), 64'd4);
                check("w4.result", 64'({c4, r4}), 64'({exp[32], exp[3:0]}));
                tick();
            end
        end
        dr4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Sequencer that drives a one-bit ALU slice LSB-first to evaluate a WIDTH-bit AND/OR/ADD operation over WIDTH clock cycles.
- Supplies the slice's a/b/carry-in bits every cycle, captures its result bit and carry-out, and assembles the full word.
- Sits between the core's multi-cycle execute path (valid/ready request) and the area-minimal datapath; trades latency for a single slice of logic.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_valid_i  input  1  request valid.
- start_ready_o  output  1  request accepted when start_valid_i && start_ready_o.
- op_i  input  2  00 AND, 01 OR, 10 ADD, 11 zero; sampled only at accept.
- a_i  input  WIDTH  operand A; sampled only at accept.
- b_i  input  WIDTH  operand B; sampled only at accept.
- result_o  output  WIDTH  final result; valid while done_valid_o = 1.
- carry_o  output  1  ADD carry-out; 0 for other ops.
- done_valid_o  output  1  result available.
- done_ready_i  input  1  consumer takes result when done_valid_o && done_ready_i.
- busy_o  output  1  high in RUN and DONE.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values (asynchronous, while rst_ni = 0): state IDLE, done_valid_o 0, result_o 0, carry_o 0, busy_o 0, counter 0, operand shifters 0. start_ready_o is decoded from state, so it reads 1 after reset.
- FSM states:
  - IDLE: start_ready_o = 1.
    - On accept: latch a_i into a_sh, b_i into b_sh, op_i into op_q; clear the carry flop; clear the counter; go to RUN.
  - RUN: start_ready_o = 0. Each cycle:
    - Slice inputs are a_sh[0], b_sh[0] and the carry flop, with op_q.
    - a_sh and b_sh shift right by one.
    - result_sh <= {slice_result, result_sh[WIDTH-1:1]}.
    - The carry flop loads slice c_out when op_q = ADD; otherwise it holds 0.
    - The counter increments.
    - When the counter = WIDTH-1, go to DONE.
  - DONE: done_valid_o = 1; result_o = result_sh; carry_o = carry flop. Hold both stable until done_ready_i = 1, then go to IDLE.
- Latency and throughput:
  - Accept at edge T gives done_valid_o = 1 after edge T+WIDTH.
  - There is no accept in the same cycle as the done handshake. Minimum issue interval is WIDTH+2 cycles.
- Input handling: inputs are ignored outside IDLE, including start_valid_i and operand changes during RUN and DONE.
- op = 11: the slice yields 0 for every bit, so result 0 and carry 0. It still takes WIDTH cycles.
- Carry chain: bit 0 carry-in is always 0 (plain add). carry_o is the carry-out of bit WIDTH-1, i.e. unsigned overflow.
- Counter: wraps to 0 on entry to RUN only; it never rolls over mid-operation.
- Reset mid-operation: abort immediately, all state goes to reset values, and no done pulse is issued.
- Backpressure: done_ready_i held low keeps DONE indefinitely with outputs stable.
- done_ready_i while not in DONE: no effect.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e: OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_ZERO = 2'b11.
  - FSM state typedef ser_state_e: IDLE, RUN, DONE.
- Instantiate the existing one-bit slice alu1 as the only sub-module; all carry logic comes from its c_out.
- FSM, shifters and counter stay in bit_serial_alu.

Test Plan:
- ADD, WIDTH = 32, a = 32'hFFFF_FFFF, b = 32'h0000_0001 -> result_o = 0, carry_o = 1; done_valid_o rises exactly 32 cycles after accept.
- AND then OR, a = 32'hF0F0_1234, b = 32'h0FF0_FFFF -> AND = 32'h00F0_1234 and OR = 32'hFFF0_FFFF, carry_o = 0 for both.
- op = 11 with a = b = 32'hDEAD_BEEF -> result 0, carry 0; a_i/b_i toggled every cycle during RUN does not change the result.
- done_ready_i held low 5 cycles after done -> result_o, done_valid_o and busy_o stable; start_ready_o = 0; a start_valid_i pulse is ignored. After the handshake, IDLE is reached and the next request is accepted one cycle later.
- rst_ni pulled low at RUN cycle 10 of an ADD -> outputs zero asynchronously, no done; a new request after release completes correctly (a = 5, b = 7 -> 12, carry 0).
- WIDTH = 4 exhaustive ADD/AND/OR over all 256 a/b pairs, checked against a reference model with back-to-back requests at maximum rate.
